// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, reset/NOP
// values and the redirect-select encoding used by the next-PC logic.
package if_stage_pkg;

  localparam int          ISA_WIDTH      = 32;
  localparam logic [31:0] INSTR_NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_VALUE = 32'h0000_0000;
  localparam logic [31:0] PC_STEP        = 32'h0000_0004;

  localparam logic [1:0]  REDIR_NONE     = 2'd0;
  localparam logic [1:0]  REDIR_BRANCH   = 2'd1;
  localparam logic [1:0]  REDIR_JUMP     = 2'd2;
  localparam logic [1:0]  REDIR_JR       = 2'd3;

endpackage

// File: rtl/if_stage_pc_next_select.sv
// Combinational next-PC selection: builds the branch, jump and jr targets,
// applies jr > jump > branch priority and qualifies redirects with ID validity.
module if_stage_pc_next_select
  import if_stage_pkg::*;
(
  input  logic [ISA_WIDTH-1:0] pc_i,
  input  logic [ISA_WIDTH-1:0] if_id_pc_plus4_i,
  input  logic                 if_id_valid_i,
  input  logic                 branch_taken_i,
  input  logic [ISA_WIDTH-1:0] branch_imm_i,
  input  logic                 jump_i,
  input  logic [25:0]          jump_index_i,
  input  logic                 jr_i,
  input  logic [ISA_WIDTH-1:0] jr_target_i,
  output logic                 redirect_o,
  output logic [ISA_WIDTH-1:0] next_pc_o
);

  logic [1:0]           sel_s;
  logic [ISA_WIDTH-1:0] branch_tgt_s;
  logic [ISA_WIDTH-1:0] jump_tgt_s;
  logic [ISA_WIDTH-1:0] jr_tgt_s;

  assign branch_tgt_s = if_id_pc_plus4_i + {branch_imm_i[ISA_WIDTH-3:0], 2'b00};
  assign jump_tgt_s   = {if_id_pc_plus4_i[31:28], jump_index_i, 2'b00};
  assign jr_tgt_s     = {jr_target_i[31:2], 2'b00};

  // A bubble in ID carries no real control instruction, so it never redirects.
  always_comb begin
    sel_s = REDIR_NONE;
    if (!if_id_valid_i) begin
      sel_s = REDIR_NONE;
    end else if (jr_i) begin
      sel_s = REDIR_JR;
    end else if (jump_i) begin
      sel_s = REDIR_JUMP;
    end else if (branch_taken_i) begin
      sel_s = REDIR_BRANCH;
    end else begin
      sel_s = REDIR_NONE;
    end
  end

  always_comb begin
    next_pc_o = pc_i + PC_STEP;
    case (sel_s)
      REDIR_BRANCH: next_pc_o = branch_tgt_s;
      REDIR_JUMP:   next_pc_o = jump_tgt_s;
      REDIR_JR:     next_pc_o = jr_tgt_s;
      REDIR_NONE:   next_pc_o = pc_i + PC_STEP;
      default:      next_pc_o = pc_i + PC_STEP;
    endcase
  end

  assign redirect_o = (sel_s != REDIR_NONE);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address and the IF/ID
// pipeline register, with stall hold and one-bubble flush on ID-stage redirects.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ISA_WIDTH-1:0] RESET_PC = PC_RESET_VALUE,
  parameter logic [ISA_WIDTH-1:0] NOP_WORD = INSTR_NOP
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [ISA_WIDTH-1:0] branch_imm_i,
  input  logic                 jump_i,
  input  logic [25:0]          jump_index_i,
  input  logic                 jr_i,
  input  logic [ISA_WIDTH-1:0] jr_target_i,
  output logic [ISA_WIDTH-1:0] imem_addr_o,
  input  logic [ISA_WIDTH-1:0] imem_data_i,
  output logic [ISA_WIDTH-1:0] if_id_pc_plus4_o,
  output logic [ISA_WIDTH-1:0] if_id_instruction_o,
  output logic                 if_id_valid_o
);

  logic [ISA_WIDTH-1:0] pc_q, pc_d;
  logic [ISA_WIDTH-1:0] instr_q, instr_d;
  logic [ISA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                 valid_q, valid_d;
  logic                 redirect_s;
  logic [ISA_WIDTH-1:0] next_pc_s;

  if_stage_pc_next_select u_pc_next_select (
    .pc_i             (pc_q),
    .if_id_pc_plus4_i (pc_plus4_q),
    .if_id_valid_i    (valid_q),
    .branch_taken_i   (branch_taken_i),
    .branch_imm_i     (branch_imm_i),
    .jump_i           (jump_i),
    .jump_index_i     (jump_index_i),
    .jr_i             (jr_i),
    .jr_target_i      (jr_target_i),
    .redirect_o       (redirect_s),
    .next_pc_o        (next_pc_s)
  );

  // Stall outranks redirect: the ID operands driving a redirect are not final yet.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (stall_i) begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end else if (redirect_s) begin
      pc_d       = next_pc_s;
      instr_d    = NOP_WORD;
      pc_plus4_d = {ISA_WIDTH{1'b0}};
      valid_d    = 1'b0;
    end else begin
      pc_d       = next_pc_s;
      instr_d    = imem_data_i;
      pc_plus4_d = pc_q + PC_STEP;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= {ISA_WIDTH{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_addr_o         = pc_q;
  assign if_id_pc_plus4_o    = pc_plus4_q;
  assign if_id_instruction_o = instr_q;
  assign if_id_valid_o       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, jr;
  logic [31:0] branch_imm, jr_target;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_data, if_id_pc_plus4, if_id_instruction;
  logic        if_id_valid;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: architectural PC and IF/ID contents.
  logic [31:0] m_pc = 32'h0, m_ins = 32'h0, m_p4 = 32'h0;
  logic        m_v  = 1'b0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 32'hA5A5_0000;

  if_stage dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .stall_i             (stall),
    .branch_taken_i      (branch_taken),
    .branch_imm_i        (branch_imm),
    .jump_i              (jump),
    .jump_index_i        (jump_index),
    .jr_i                (jr),
    .jr_target_i         (jr_target),
    .imem_addr_o         (imem_addr),
    .imem_data_i         (imem_data),
    .if_id_pc_plus4_o    (if_id_pc_plus4),
    .if_id_instruction_o (if_id_instruction),
    .if_id_valid_o       (if_id_valid)
  );

  task automatic clear_inputs();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    branch_imm = 32'h0; jr_target = 32'h0; jump_index = 26'h0;
  endtask

  // One clock: predict the next state from the current inputs, then advance.
  task automatic cycle();
    logic [31:0] n_pc, n_ins, n_p4, tgt;
    logic        n_v, redir;
    n_pc = m_pc; n_ins = m_ins; n_p4 = m_p4; n_v = m_v;
    if (rst) begin
      n_pc = 32'h0; n_ins = 32'h0; n_p4 = 32'h0; n_v = 1'b0;
    end else if (!stall) begin
      redir = m_v && (jr || jump || branch_taken);
      if (jr)        tgt = jr_target & 32'hFFFF_FFFC;
      else if (jump) tgt = (m_p4 & 32'hF000_0000) | (32'(jump_index) * 32'd4);
      else           tgt = m_p4 + branch_imm * 32'd4;
      if (redir) begin
        n_pc = tgt; n_ins = 32'h0; n_p4 = 32'h0; n_v = 1'b0;
      end else begin
        n_pc = m_pc + 32'd4; n_ins = m_pc ^ 32'hA5A5_0000; n_p4 = m_pc + 32'd4; n_v = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ins = n_ins; m_p4 = n_p4; m_v = n_v;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !== {32'h0, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_state: got pc=%h v=%b ins=%h p4=%h, want pc=0 v=0 ins=0 p4=0",
               imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] e_p4;
    for (int i = 0; i < 6; i++) begin
      cycle();
      e_p4 = 32'd4 * 32'(i + 1);
      total++;
      if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !==
          {e_p4, 1'b1, (e_p4 - 32'd4) ^ 32'hA5A5_0000, e_p4}) begin
        bad++;
        $display("FAIL free_run[%0d]: got pc=%h v=%b ins=%h p4=%h, want pc=%h v=1 ins=%h p4=%h",
                 i, imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4,
                 e_p4, (e_p4 - 32'd4) ^ 32'hA5A5_0000, e_p4);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    branch_taken = 1'b1; branch_imm = 32'hFFFF_FFFE;
    cycle();
    total++;
    if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !== {32'h8, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL branch_flush: got pc=%h v=%b ins=%h p4=%h, want pc=8 v=0 ins=0 p4=0",
               imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4);
    end
    branch_taken = 1'b0;
    cycle();
    total++;
    if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !==
        {32'hC, 1'b1, 32'hA5A5_0008, 32'hC}) begin
      bad++;
      $display("FAIL branch_target: got pc=%h v=%b ins=%h p4=%h, want pc=c v=1 ins=a5a50008 p4=c",
               imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4);
    end
  endtask

  // Brings IF/ID to pc_plus4 = 0x4000_0010 (valid) using a jr to 0x4000_000C.
  task automatic setup_p4_40000010();
    clear_inputs();
    jr = 1'b1; jr_target = 32'h4000_000C;
    cycle();
    clear_inputs();
    cycle();
  endtask

  task automatic test_jump_jr();
    setup_p4_40000010();
    total++;
    if ({if_id_valid, if_id_pc_plus4} !== {1'b1, 32'h4000_0010}) begin
      bad++;
      $display("FAIL jr_setup: got v=%b p4=%h, want v=1 p4=40000010", if_id_valid, if_id_pc_plus4);
    end
    jump = 1'b1; jump_index = 26'h0000100; jr = 1'b1; jr_target = 32'h0000_0123;
    cycle();
    total++;
    if ({imem_addr, if_id_valid} !== {32'h0000_0120, 1'b0}) begin
      bad++;
      $display("FAIL jr_priority: got pc=%h v=%b, want pc=00000120 v=0", imem_addr, if_id_valid);
    end
    clear_inputs();
    cycle();
    setup_p4_40000010();
    jump = 1'b1; jump_index = 26'h0000100; jr = 1'b0; jr_target = 32'h0000_0123;
    cycle();
    total++;
    if ({imem_addr, if_id_valid} !== {32'h4000_0400, 1'b0}) begin
      bad++;
      $display("FAIL jump_target: got pc=%h v=%b, want pc=40000400 v=0", imem_addr, if_id_valid);
    end
    clear_inputs();
  endtask

  task automatic test_stall_redirect();
    logic [31:0] s_pc, s_ins, s_p4, imm;
    cycle();
    s_pc = imem_addr; s_ins = if_id_instruction; s_p4 = if_id_pc_plus4;
    imm = 32'($urandom_range(64)) - 32'd32;
    stall = 1'b1; branch_taken = 1'b1; branch_imm = imm;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !== {s_pc, 1'b1, s_ins, s_p4}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got pc=%h v=%b ins=%h p4=%h, want pc=%h v=1 ins=%h p4=%h",
                 i, imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4, s_pc, s_ins, s_p4);
      end
    end
    stall = 1'b0;
    cycle();
    total++;
    if ({imem_addr, if_id_valid} !== {s_p4 + imm * 32'd4, 1'b0}) begin
      bad++;
      $display("FAIL stall_release: got pc=%h v=%b, want pc=%h v=0", imem_addr, if_id_valid, s_p4 + imm * 32'd4);
    end
  endtask

  task automatic test_bubble();
    logic [31:0] s_pc;
    s_pc = imem_addr;
    branch_taken = 1'b1; branch_imm = 32'h0000_0040;
    cycle();
    total++;
    if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !==
        {s_pc + 32'd4, 1'b1, s_pc ^ 32'hA5A5_0000, s_pc + 32'd4}) begin
      bad++;
      $display("FAIL bubble_no_redirect: got pc=%h v=%b ins=%h p4=%h, want pc=%h v=1 ins=%h p4=%h",
               imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4,
               s_pc + 32'd4, s_pc ^ 32'hA5A5_0000, s_pc + 32'd4);
    end
    clear_inputs();
  endtask

  task automatic test_wrap_reset();
    jr = 1'b1; jr_target = 32'hFFFF_FFFF;
    cycle();
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_setup: got pc=%h, want fffffffc", imem_addr);
    end
    clear_inputs();
    cycle();
    total++;
    if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !== {32'h0, 1'b1, 32'h5A5A_FFFC, 32'h0}) begin
      bad++;
      $display("FAIL pc_wrap: got pc=%h v=%b ins=%h p4=%h, want pc=0 v=1 ins=5a5afffc p4=0",
               imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4);
    end
    cycle();
    rst = 1'b1; stall = 1'b1; jump = 1'b1; jump_index = 26'h3FF_FFFF;
    cycle();
    total++;
    if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !== {32'h0, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_mid_op: got pc=%h v=%b ins=%h p4=%h, want pc=0 v=0 ins=0 p4=0",
               imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(63) == 0);
      stall        = ($urandom_range(3) == 0);
      branch_taken = ($urandom_range(3) == 0);
      jump         = ($urandom_range(5) == 0);
      jr           = ($urandom_range(7) == 0);
      branch_imm   = 32'($urandom_range(256)) - 32'd128;
      jump_index   = 26'($urandom);
      jr_target    = $urandom;
      cycle();
      total++;
      if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4} !== {m_pc, m_v, m_ins, m_p4}) begin
        bad++;
        $display("FAIL random[%0d]: got pc=%h v=%b ins=%h p4=%h, want pc=%h v=%b ins=%h p4=%h",
                 i, imem_addr, if_id_valid, if_id_instruction, if_id_pc_plus4, m_pc, m_v, m_ins, m_p4);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_free_run();
    test_branch();
    test_jump_jr();
    test_stall_redirect();
    test_bubble();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. Holds the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register.
- Takes redirect requests (taken beq/bnq, j/jal, jr) resolved in the ID stage, where the branch-condition result is computed.
- Takes stall requests from the hazard unit.
- No branch delay slot: a redirect flushes the wrong-path instruction fetched that cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard hold: freeze PC and IF/ID.
- branch_taken  in  1  ID-stage conditional branch resolved taken (branch decoded AND condition satisfied).
- branch_imm  in  `ISA_WIDTH  sign-extended 16-bit immediate of the ID instruction.
- jump  in  1  ID instruction is j/jal.
- jump_index  in  26  instr[25:0] of the ID instruction.
- jr  in  1  ID instruction is jr.
- jr_target  in  `ISA_WIDTH  forwarded rs value for jr.
- imem_addr  out  `ISA_WIDTH  byte address to instruction memory (= PC).
- imem_data  in  `ISA_WIDTH  instruction word; combinational read of imem_addr, valid same cycle.
- if_id_pc_plus4  out  `ISA_WIDTH  PC+4 of the instruction held in IF/ID.
- if_id_instruction  out  `ISA_WIDTH  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=1 at a rising edge) overrides all other inputs, including stall:
  - pc <= RESET_PC.
  - if_id_instruction <= NOP_WORD, if_id_pc_plus4 <= 0, if_id_valid <= 0.
- imem_addr = pc, continuously. The first fetch after reset is at RESET_PC in the cycle after reset deasserts.
- Redirect targets (all 32-bit, modulo 2^32, wrap silently):
  - Branch target = if_id_pc_plus4 + (branch_imm << 2).
  - Jump target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
  - Jr target = {jr_target[31:2], 2'b00}; low bits are forced to zero.
- Redirect priority: jr > jump > branch_taken. Any one of them asserted = redirect.
- Redirects are qualified by if_id_valid: a bubble in ID never redirects.
- Per rising edge, when not in reset:
  - stall=1: pc, if_id_instruction, if_id_pc_plus4 and if_id_valid all hold. Redirect inputs are ignored, because the ID operands are not yet final. Stall therefore beats a redirect in the same cycle.
  - stall=0, redirect: pc <= target. IF/ID <= NOP_WORD, pc_plus4 <= 0, valid <= 0 (flush of the wrong-path fetch).
  - stall=0, no redirect: pc <= pc + 4. IF/ID <= {imem_data, pc + 4}, valid <= 1.
- Latency: redirect seen in cycle N → target fetched in cycle N+1, and the target instruction is in IF/ID at N+2. Exactly one bubble per taken redirect.
- PC increment wraps 32'hFFFF_FFFC → 32'h0000_0000.
- Back-to-back redirects are legal. The flushed bubble cannot redirect, so a redirect can be followed at the earliest by another one two cycles later.
- Reset mid-stall or mid-redirect: reset wins. The state after reset is identical to the power-on state.
- All outputs are registered except imem_addr, which is direct from the pc register.

Decomposition:
- Shared definitions include: ISA_WIDTH, INSTR_NOP, PC_RESET_VALUE, and the redirect-select encoding (REDIR_NONE/BRANCH/JUMP/JR, 2 bits).
- One natural sub-module: pc_next_select. It is combinational: computes the three targets, applies the priority and valid qualification, and outputs the redirect flag and next_pc.
- The PC register and the IF/ID register stay in if_stage.

Test Plan:
- Reset then free-run with imem returning addr^32'hA5A5_0000:
  - if_id_valid=0 first cycle after reset.
  - Then IF/ID shows pc_plus4 = 4, 8, 12… with matching instruction words.
  - imem_addr = 0, 4, 8, ….
- Branch redirect:
  - Setup: IF/ID pc_plus4=32'h0000_0010, branch_taken=1, branch_imm=32'hFFFF_FFFE.
  - Next pc = 32'h0000_0008.
  - Next IF/ID = NOP with valid=0.
  - A further cycle later IF/ID holds the word from 0x8 with pc_plus4=0xC.
- Jump/jr priority:
  - Setup: pc_plus4=32'h4000_0010, jump=1, jump_index=26'h0000100, jr=1, jr_target=32'h0000_0123, all same cycle.
  - Next pc = 32'h0000_0120 (jr wins, low bits cleared).
  - Repeat with jr=0: next pc = 32'h4000_0400.
- Stall vs redirect:
  - stall=1 and branch_taken=1 for 3 cycles: pc, IF/ID and valid are unchanged across all 3.
  - Drop stall: redirect is taken on that edge.
- Bubble does not redirect: if_id_valid=0 with branch_taken=1 → pc <= pc+4, no flush.
- Wrap and mid-operation reset:
  - Force pc to 32'hFFFF_FFFC (via jr target): next sequential pc = 0.
  - Assert rst together with stall=1 and jump=1: pc=RESET_PC, valid=0 on the next edge.
